// File: rtl/mv_row_sequencer_if.sv
// Row-sequencer handshake bundle: job control, column-beat stream, MAC strobes and row writeback.
// master = sequencer side, slave = fetch/step-counter/MAC/writeback side.
interface mv_row_sequencer_if #(
  parameter int unsigned ROW_WIDTH = 11
);
  logic                 start;
  logic [ROW_WIDTH-1:0] n_rows;
  logic                 col_ov;
  logic                 cnt;
  logic                 beat_valid;
  logic                 beat_ready;
  logic                 acc_en;
  logic                 acc_clr;
  logic                 row_valid;
  logic                 row_ready;
  logic [ROW_WIDTH-1:0] row_idx;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, n_rows, col_ov, beat_valid, row_ready,
    output cnt, beat_ready, acc_en, acc_clr, row_valid, row_idx, busy, done
  );

  modport slave (
    output start, n_rows, col_ov, beat_valid, row_ready,
    input  cnt, beat_ready, acc_en, acc_clr, row_valid, row_idx, busy, done
  );
endinterface

// File: rtl/mv_row_sequencer.sv
// Row-level control FSM of the matrix-vector accelerator: streams column beats into the
// step counter until it overflows, drains the MAC pipeline, then hands each row downstream.
module mv_row_sequencer #(
  parameter int unsigned ROW_WIDTH = 11,
  parameter int unsigned ACC_LAT   = 3
) (
  input  logic                clk,
  input  logic                rstn,
  mv_row_sequencer_if.master  bus
);
  localparam int unsigned DW = 4;

  typedef enum logic [1:0] {IDLE, ROW, DRAIN, EMIT} state_e;

  state_e               state_q, state_d;
  logic [ROW_WIDTH-1:0] row_idx_q, row_idx_d;
  logic [ROW_WIDTH-1:0] n_rows_q, n_rows_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic                 acc_clr_q, acc_clr_d;
  logic                 row_valid_q, row_valid_d;
  logic                 done_q, done_d;
  logic                 beat_ready_c;

  // Never accept a beat while the step counter reports overflow, so no beat crosses a row.
  assign beat_ready_c   = (state_q == ROW) && !bus.col_ov;
  assign bus.beat_ready = beat_ready_c;
  assign bus.cnt        = beat_ready_c & bus.beat_valid;
  assign bus.acc_en     = beat_ready_c & bus.beat_valid;
  assign bus.acc_clr    = acc_clr_q;
  assign bus.row_valid  = row_valid_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;

  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    n_rows_d    = n_rows_q;
    drain_d     = drain_q;
    acc_clr_d   = 1'b0;
    row_valid_d = row_valid_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (bus.start && !done_q) begin
          if (bus.n_rows != '0) begin
            n_rows_d  = bus.n_rows;
            row_idx_d = '0;
            acc_clr_d = 1'b1;
            state_d   = ROW;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ROW: begin
        if (bus.col_ov) begin
          if (ACC_LAT == 0) begin
            row_valid_d = 1'b1;
            state_d     = EMIT;
          end else begin
            drain_d = DW'(ACC_LAT - 1);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          row_valid_d = 1'b1;
          state_d     = EMIT;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      EMIT: begin
        if (bus.row_ready) begin
          row_valid_d = 1'b0;
          if (row_idx_q == n_rows_q - ROW_WIDTH'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_idx_d = row_idx_q + ROW_WIDTH'(1);
            acc_clr_d = 1'b1;
            state_d   = ROW;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      row_idx_q   <= '0;
      n_rows_q    <= '0;
      drain_q     <= '0;
      acc_clr_q   <= 1'b0;
      row_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      n_rows_q    <= n_rows_d;
      drain_q     <= drain_d;
      acc_clr_q   <= acc_clr_d;
      row_valid_q <= row_valid_d;
      done_q      <= done_d;
    end
  end
endmodule
